mul_partial_combiner: RTL
=========================

Name: mul_partial_combiner

Overview:
Downstream of the three-product 16x16 multiplier cell. Consumes its partial products p1 (a_lo*b_lo), p2 (a_lo*b_hi) and p3 (a_hi*b_lo). Forms the low 32 bits of the 32x32 product through a 2-stage valid/ready pipeline. Returns the product with a destination tag to the CPU writeback path, with backpressure and a pipeline flush.

Parameters:
TAG_W, 5, width of the destination-register tag carried alongside each product
HALF_W, 16, half-word width; result width is 2*HALF_W (fixed 32 in this design)

Ports:
clk  in  1  single clock; all state rises on posedge
reset  in  1  asynchronous, active-high reset; clears all state immediately
in_valid  in  1  partial products and tag are valid this cycle
in_ready  out  1  block can accept input this cycle
in_p1  in  32  a_lo*b_lo
in_p2  in  32  a_lo*b_hi
in_p3  in  32  a_hi*b_lo
in_tag  in  TAG_W  destination tag, passed through unchanged
flush  in  1  kill all in-flight operations (exception/pipeline kill)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result this cycle
out_result  out  32  low 32 bits of product
out_tag  out  TAG_W  tag of out_result

Behaviour:
- Stage 1 register (s1_valid, s1_p1[31:0], s1_mid[15:0], s1_tag).
  - s1_mid = in_p2[15:0] + in_p3[15:0], truncated to 16 bits; carry discarded.
  - Upper halves of p2/p3 are ignored (they only affect bits >= 32).
- Stage 2 / output register (out_valid, out_result, out_tag).
  - out_result = s1_p1 + {s1_mid, 16'h0000}, mod 2^32.
- Advance rules:
  - s2_load = s1_valid & (~out_valid | out_ready).
  - s1_load = in_valid & in_ready.
  - in_ready = ~s1_valid | s2_load (combinational).
  - in_ready is forced 0 while reset is high.
- Stage registers load only on their load condition. Otherwise they hold; no bubbles are inserted while data is stalled.
- Valid bits:
  - s1_valid next = s1_load ? 1 : (s2_load ? 0 : s1_valid).
  - out_valid next = s2_load ? 1 : ((out_valid & out_ready) ? 0 : out_valid).
- Latency: an input accepted at cycle N produces out_valid=1 at cycle N+2 when not stalled. Throughput is 1 op/cycle.
- Stall: while out_valid=1 and out_ready=0, out_result and out_tag hold stable. At most 2 ops are in flight; a third is refused (in_ready=0).
- Ordering: strictly FIFO; tags emerge in acceptance order.
- Flush:
  - At the next edge, clears s1_valid and out_valid.
  - Data registers need not be cleared.
  - An input offered in the same cycle as flush is dropped (flush wins over accept).
  - A result handshaken in the flush cycle (out_valid & out_ready) counts as delivered.
  - in_ready is unaffected by flush in that cycle.
- Reset: asynchronous assert clears s1_valid, out_valid, out_result=0, out_tag=0 and s1 data=0, whether or not an operation is in flight. Normal operation resumes on the first edge after deassertion.
- Invalid input (in_valid=0) never changes state, regardless of in_p*/in_tag values.

Test Plan:
- Basic product: p1=0x0000000F, p2=0x0000000C, p3=0x0000000A, tag=3 (src1=0x00020003, src2=0x00040005), out_ready=1 -> two cycles later out_valid=1, out_result=0x0016000F, out_tag=3.
- Wrap/truncation:
  - p1=0xFFFF0000, p2=0xABCD0001, p3=0x12340000 -> out_result=0x00000000.
  - p2[15:0]=0xFFFF, p3[15:0]=0x0001, p1=0xFFFFFFFF -> 0xFFFFFFFF (mid carry discarded).
- Backpressure: out_ready=0 for 5 cycles while ops tags 1,2,3 are offered back-to-back.
  - Tags 1 and 2 are accepted; in_ready=0 from then on; out_result/out_tag hold on tag 1.
  - After out_ready=1: tags 1,2,3 emerge on consecutive cycles.
- Throughput: 8 consecutive ops with out_ready=1 -> 8 consecutive out_valid cycles, each at acceptance+2, tags in order.
- Flush: two ops in flight, plus a third offered with flush=1 -> the next cycle out_valid=0 and s1 is empty; the third op never appears.
- Reset mid-op: reset asserted asynchronously between edges with two ops in flight -> out_valid=0, out_result=0, out_tag=0 immediately. A new op after deassertion completes with the correct result at +2.

Source files
------------

// File: rtl/mul_partial_combiner.sv
// ============================================================================
// Module   : mul_partial_combiner
// Purpose  : Combines 16x16 partial products into the low 32 bits of a 32x32
//            product through a two-stage valid/ready pipeline with flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mul_partial_combiner #(
    parameter int TAG_W  = 5,
    parameter int HALF_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*HALF_W-1:0]   in_p1,
    input  logic [2*HALF_W-1:0]   in_p2,
    input  logic [2*HALF_W-1:0]   in_p3,
    input  logic [TAG_W-1:0]      in_tag,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*HALF_W-1:0]   out_result,
    output logic [TAG_W-1:0]      out_tag
);

    localparam int c_RES_W = 2 * HALF_W;

    logic                 r_s1_valid;
    logic [c_RES_W-1:0]   r_s1_p1;
    logic [HALF_W-1:0]    r_s1_mid;
    logic [TAG_W-1:0]     r_s1_tag;
    logic                 r_out_valid;
    logic [c_RES_W-1:0]   r_out_result;
    logic [TAG_W-1:0]     r_out_tag;

    logic                 w_s1_load;
    logic                 w_s2_load;
    logic [HALF_W-1:0]    w_mid;
    logic [c_RES_W-1:0]   w_sum;
    logic                 w_unused_hi;

    // Upper halves of p2/p3 only contribute to product bits >= 32.
    assign w_unused_hi = ^{in_p2[c_RES_W-1:HALF_W], in_p3[c_RES_W-1:HALF_W]};

    assign w_s2_load = r_s1_valid & (~r_out_valid | out_ready);
    assign in_ready  = ~reset & (~r_s1_valid | w_s2_load);
    assign w_s1_load = in_valid & in_ready;

    assign w_mid = in_p2[HALF_W-1:0] + in_p3[HALF_W-1:0];
    assign w_sum = r_s1_p1 + {r_s1_mid, {HALF_W{1'b0}}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid   <= 1'b0;
            r_s1_p1      <= '0;
            r_s1_mid     <= '0;
            r_s1_tag     <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_tag    <= '0;
        end else begin
            if (flush)
                r_s1_valid <= 1'b0;
            else if (w_s1_load)
                r_s1_valid <= 1'b1;
            else if (w_s2_load)
                r_s1_valid <= 1'b0;

            // A handshake in the flush cycle still completes; flush only kills validity.
            if (flush)
                r_out_valid <= 1'b0;
            else if (w_s2_load)
                r_out_valid <= 1'b1;
            else if (r_out_valid & out_ready)
                r_out_valid <= 1'b0;

            if (w_s1_load && !flush) begin
                r_s1_p1  <= in_p1;
                r_s1_mid <= w_mid;
                r_s1_tag <= in_tag;
            end

            if (w_s2_load && !flush) begin
                r_out_result <= w_sum;
                r_out_tag    <= r_s1_tag;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_tag    = r_out_tag;

endmodule

`default_nettype wire
